// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter onto one fixed-latency memory port
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    input  logic              flush,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0]   starve_cnt;
    logic               if_win;
    // Per-stage read tag: valid plus owner (1 = load/store, 0 = fetch)
    logic [MEM_LAT-1:0] tag_valid;
    logic [MEM_LAT-1:0] tag_ls;
    logic               exit_valid;
    logic               exit_ls;

    // Fetch takes the port when uncontested or once it has been starved long enough
    assign if_win = if_req && !flush && (!ls_req || starve_cnt == STARVE_LIM);
    assign if_gnt = !reset && if_win;
    assign ls_gnt = !reset && ls_req && !if_win;

    assign mem_en    = if_gnt | ls_gnt;
    assign mem_we    = ls_gnt & ls_we;
    assign mem_addr  = if_gnt ? if_addr : ls_addr;
    assign mem_wdata = ls_wdata;

    always_ff @(posedge clk) begin
        if (reset || flush || !if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_valid <= '0;
            tag_ls    <= '0;
        end else begin
            tag_valid[0] <= if_gnt | (ls_gnt & ~ls_we);
            tag_ls[0]    <= ls_gnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1] & ~(flush & ~tag_ls[i-1]);
                tag_ls[i]    <= tag_ls[i-1];
            end
        end
    end

    assign exit_valid = tag_valid[MEM_LAT-1];
    assign exit_ls    = tag_ls[MEM_LAT-1];

    // A flush also kills the fetch response leaving the pipe this cycle
    assign if_rvalid = !reset && exit_valid && !exit_ls && !flush;
    assign ls_rvalid = !reset && exit_valid && exit_ls;
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              flush;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .flush(flush),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs change
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; flush = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            idle_inputs();
        end
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1; flush = 1'b0;
        if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; mem_rdata = 32'h0;

        // Reset holds every output low even with requests pending
        @(negedge clk);
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_ls_gnt", ls_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_ls_rvalid", ls_rvalid, 0);

        // Single fetch straight out of reset
        cyc();
        reset = 1'b0; idle_inputs(); if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("f1_if_gnt", if_gnt, 1);
        chk("f1_ls_gnt", ls_gnt, 0);
        chk("f1_mem_en", mem_en, 1);
        chk("f1_mem_addr", mem_addr, 32'h100);
        chk("f1_mem_we", mem_we, 0);
        cyc(); idle_inputs();
        @(negedge clk);
        chk("f1_rvalid_early", if_rvalid, 0);
        cyc(); mem_rdata = 32'hA5A5_0001;
        @(negedge clk);
        chk("f1_if_rvalid", if_rvalid, 1);
        chk("f1_if_rdata", if_rdata, 32'hA5A5_0001);
        chk("f1_ls_rvalid", ls_rvalid, 0);
        cyc();
        @(negedge clk);
        chk("f1_rvalid_late", if_rvalid, 0);

        // Both requesting continuously: 4 loads then 1 fetch, repeating
        drain(2);
        for (int i = 0; i < 10; i++) begin
            cyc();
            if_req = 1'b1; if_addr = 32'h500 + i; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h600 + i;
            @(negedge clk);
            chk($sformatf("st_if_gnt_%0d", i), if_gnt, (i % 5 == 4));
            chk($sformatf("st_ls_gnt_%0d", i), ls_gnt, (i % 5 != 4));
            chk($sformatf("st_addr_%0d", i), mem_addr, (i % 5 == 4) ? 32'h500 + i : 32'h600 + i);
        end

        // Dropping if_req clears the starvation count
        drain(3);
        for (int i = 0; i < 9; i++) begin
            cyc();
            if_req = (i != 3); ls_req = 1'b1; ls_we = 1'b0;
            @(negedge clk);
            chk($sformatf("clr_if_gnt_%0d", i), if_gnt, (i == 8));
        end

        // Store: write strobe, no response
        drain(3);
        cyc();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("st_ls_gnt", ls_gnt, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_addr", mem_addr, 32'h200);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            cyc(); idle_inputs();
            @(negedge clk);
            chk($sformatf("st_no_ls_rvalid_%0d", i), ls_rvalid, 0);
            chk($sformatf("st_no_if_rvalid_%0d", i), if_rvalid, 0);
        end

        // Fetches at cycles 0 and 1, flush at cycle 2: neither returns
        drain(2);
        cyc(); if_req = 1'b1; if_addr = 32'h300;
        cyc(); if_addr = 32'h304;
        cyc(); flush = 1'b1;
        @(negedge clk);
        chk("fl_if_gnt_blocked", if_gnt, 0);
        chk("fl_if_rvalid_c2", if_rvalid, 0);
        cyc(); idle_inputs();
        @(negedge clk);
        chk("fl_if_rvalid_c3", if_rvalid, 0);
        cyc();
        @(negedge clk);
        chk("fl_if_rvalid_c4", if_rvalid, 0);

        // Fetch at 0, load at 1, flush at 2 with a new load: loads survive
        drain(2);
        cyc(); if_req = 1'b1; if_addr = 32'h310;
        cyc(); if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400;
        cyc(); flush = 1'b1; ls_addr = 32'h404;
        @(negedge clk);
        chk("fl2_ls_gnt", ls_gnt, 1);
        chk("fl2_if_rvalid_c2", if_rvalid, 0);
        chk("fl2_ls_rvalid_c2", ls_rvalid, 0);
        cyc(); idle_inputs(); mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("fl2_ls_rvalid_c3", ls_rvalid, 1);
        chk("fl2_ls_rdata_c3", ls_rdata, 32'h1234_5678);
        cyc(); mem_rdata = 32'h8765_4321;
        @(negedge clk);
        chk("fl2_ls_rvalid_c4", ls_rvalid, 1);
        chk("fl2_ls_rdata_c4", ls_rdata, 32'h8765_4321);

        // Alternating fetch/load reads route to the matching response port
        drain(3);
        for (int c = 0; c < 8; c++) begin
            cyc();
            idle_inputs();
            if (c < 6) begin
                if_req = (c % 2 == 0); ls_req = (c % 2 == 1); if_addr = 32'h700 + c; ls_addr = 32'h800 + c;
            end
            mem_rdata = 32'h1000 + c;
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("alt_if_rvalid_%0d", c), if_rvalid, (c % 2 == 0));
                chk($sformatf("alt_ls_rvalid_%0d", c), ls_rvalid, (c % 2 == 1));
                chk($sformatf("alt_rdata_%0d", c), (c % 2 == 0) ? if_rdata : ls_rdata, 32'h1000 + c);
            end
        end

        // Reset one cycle after a grant discards that read
        drain(3);
        cyc(); if_req = 1'b1; if_addr = 32'h900;
        @(negedge clk);
        chk("rr_if_gnt", if_gnt, 1);
        cyc(); reset = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
        @(negedge clk);
        chk("rr_if_gnt_rst", if_gnt, 0);
        chk("rr_ls_gnt_rst", ls_gnt, 0);
        chk("rr_mem_en_rst", mem_en, 0);
        chk("rr_mem_we_rst", mem_we, 0);
        chk("rr_if_rvalid_rst", if_rvalid, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(); reset = 1'b0; idle_inputs();
            @(negedge clk);
            chk($sformatf("rr_if_rvalid_%0d", i), if_rvalid, 0);
            chk($sformatf("rr_ls_rvalid_%0d", i), ls_rvalid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports.
REQ-003 Parameter MEM_LAT, default 2, fixed memory read latency in cycles (≥1).
REQ-004 Parameter STARVE_MAX, default 4, consecutive fetch denials that force a fetch grant (≥1).
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 if_req  in  1  fetch read request.
REQ-009 if_addr  in  ADDR_W  fetch address.
REQ-010 if_gnt  out  1  fetch request accepted this cycle.
REQ-011 if_rvalid  out  1  fetch read data valid.
REQ-012 if_rdata  out  DATA_W  fetch read data.
REQ-013 ls_req  in  1  load/store request.
REQ-014 ls_we  in  1  1 = store, 0 = load.
REQ-015 ls_addr  in  ADDR_W  load/store address.
REQ-016 ls_wdata  in  DATA_W  store data.
REQ-017 ls_gnt  out  1  load/store request accepted this cycle.
REQ-018 ls_rvalid  out  1  load data valid.
REQ-019 ls_rdata  out  DATA_W  load data.
REQ-020 flush  in  1  mispredict recovery; cancels in-flight fetch reads.
REQ-021 mem_en  out  1  memory access strobe.
REQ-022 mem_we  out  1  memory write enable.
REQ-023 mem_addr  out  ADDR_W  memory address.
REQ-024 mem_wdata  out  DATA_W  memory write data.
REQ-025 mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read strobe.

Function
REQ-026 Grants are combinational from the same-cycle requests; at most one of if_gnt/ls_gnt is high per cycle.
REQ-027 Default priority: load/store wins when ls_req=1.
REQ-028 A starvation counter increments each cycle if_req=1 and if_gnt=0, saturating at STARVE_MAX.
REQ-029 The counter clears to 0 on any cycle with if_gnt=1 or if_req=0.
REQ-030 When the counter equals STARVE_MAX and if_req=1, fetch wins over load/store.
REQ-031 When flush=1, if_gnt is forced to 0, ls arbitration is unaffected, and the counter clears.
REQ-032 mem_en equals if_gnt|ls_gnt; mem_addr/mem_we/mem_wdata come from the granted requester; with no grant, mem_we=0 and the other memory outputs are don't-care.
REQ-033 A MEM_LAT-deep tag shift pipeline records {valid, owner} per read issued (valid=0 for stores and idle cycles).
REQ-034 At pipeline exit, a valid IF tag asserts if_rvalid and a valid LS tag asserts ls_rvalid; both rdata outputs are driven combinationally from mem_rdata.
REQ-035 At most one of if_rvalid/ls_rvalid is high per cycle.
REQ-036 Stores produce no response.
REQ-037 flush=1 clears valid on every in-flight IF tag, including the one exiting this cycle, so if_rvalid=0 that cycle.
REQ-038 flush never affects in-flight LS tags.
REQ-039 Read responses arrive in issue order, exactly MEM_LAT cycles after grant.

Reset
REQ-040 While reset=1: if_gnt=ls_gnt=mem_en=mem_we=0, if_rvalid=ls_rvalid=0, the counter is 0, and all tags are invalid.
REQ-041 In-flight reads are discarded by reset and never produce rvalid.
REQ-042 The first grant is possible in the first cycle after reset deasserts.

Verification
REQ-043 Only if_req, addr 0x100 (MEM_LAT=2) -> if_gnt same cycle; if_rvalid 2 cycles later with if_rdata=mem_rdata.
REQ-044 if_req and ls_req both held continuously (STARVE_MAX=4) -> ls granted 4 cycles, then if 1 cycle, repeating 4:1.
REQ-045 ls store at 0x200 with data 0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF; no ls_rvalid afterwards.
REQ-046 Fetch reads granted at cycles 0 and 1, flush at cycle 2 -> no if_rvalid at cycles 2 or 3; a load issued at cycle 1 instead still returns at cycle 3.
REQ-047 Alternating IF/LS reads every cycle -> responses routed in order to the matching rvalid, never both high.
REQ-048 reset asserted 1 cycle after a read grant -> no rvalid ever appears for that read; outputs zero during reset.
